// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel divides CLK_in by a
// runtime-loadable N >= 2, with changes applied only at period boundaries.

module clk_div_ch #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [CNT_W-1:0] val,
  output logic             div_clk,
  output logic             tick,
  output logic             act
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] s, n, cnt, h;
  logic [CNT_W:0]   cnt_nx;
  logic             bnd, s_ok;

  // ceil(N/2) without the N+1 overflow at N = 2^CNT_W-1
  assign h      = (n >> 1) + CNT_W'(n[0]);
  assign cnt_nx = {1'b0, cnt} + 1'b1;
  // >= rather than == so a degenerate N of 0/1 reached via SYNC still ends the period
  assign bnd    = cnt_nx >= {1'b0, n};
  assign s_ok   = s >= CNT_W'(2);
  assign act    = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s       <= CNT_W'(DEF_DIV);
      n       <= CNT_W'(DEF_DIV);
      cnt     <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (ld) s <= val;
      tick <= 1'b0;
      if (sync && en && (state == RUN || s_ok)) begin
        state   <= RUN;
        n       <= s;
        cnt     <= '0;
        div_clk <= 1'b1;
        tick    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            n       <= s;
            cnt     <= '0;
            div_clk <= 1'b0;
            if (en && s_ok) begin
              state   <= RUN;
              div_clk <= 1'b1;
              tick    <= 1'b1;
            end
          end
          RUN: begin
            if (!bnd) begin
              cnt     <= cnt_nx[CNT_W-1:0];
              div_clk <= cnt_nx < {1'b0, h};
            end else begin
              n   <= s;
              cnt <= '0;
              if (!en || !s_ok) begin
                state   <= IDLE;
                div_clk <= 1'b0;
              end else begin
                div_clk <= 1'b1;
                tick    <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

module clk_div_multi #(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic              CLK_in,
  input  logic              RST,
  input  logic [NUM_CH-1:0] EN,
  input  logic              SYNC,
  input  logic              DIV_ld,
  input  logic [3:0]        DIV_ch,
  input  logic [CNT_W-1:0]  DIV_val,
  output logic [NUM_CH-1:0] CLK_out,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] ACT
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
      .clk     (CLK_in),
      .rst     (RST),
      .en      (EN[i]),
      .sync    (SYNC),
      .ld      (DIV_ld && (DIV_ch == 4'(i))),
      .val     (DIV_val),
      .div_clk (CLK_out[i]),
      .tick    (TICK[i]),
      .act     (ACT[i])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (3 channels, 8-bit, DEF_DIV=2); outputs
// are sampled 1 time unit after each rising edge.

module tb_clk_div_multi;
  logic       CLK_in = 1'b0;
  logic       RST, SYNC, DIV_ld;
  logic [2:0] EN;
  logic [3:0] DIV_ch;
  logic [7:0] DIV_val;
  logic [2:0] CLK_out, TICK, ACT;

  int checks = 0;
  int failures = 0;
  logic [2:0] msk = 3'b111;
  logic [2:0] ec[$], et[$], ea[$];
  int hi;

  clk_div_multi #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(2)) dut (
    .CLK_in(CLK_in), .RST(RST), .EN(EN), .SYNC(SYNC), .DIV_ld(DIV_ld),
    .DIV_ch(DIV_ch), .DIV_val(DIV_val), .CLK_out(CLK_out), .TICK(TICK), .ACT(ACT)
  );

  always #5 CLK_in = ~CLK_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_in);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = '0; SYNC = 1'b0; DIV_ld = 1'b0;
    step();
    RST = 1'b0;
  endtask

  task automatic pulse_load(input logic [3:0] ch, input logic [7:0] v);
    DIV_ld = 1'b1; DIV_ch = ch; DIV_val = v;
    step();
    DIV_ld = 1'b0;
  endtask

  // Steps through the queued expectations; one-shot strobes drop after the first edge.
  task automatic play(input string tag);
    for (int i = 0; i < ec.size(); i++) begin
      step();
      if (i == 0) begin DIV_ld = 1'b0; SYNC = 1'b0; end
      chk($sformatf("%s.clk[%0d]", tag, i), 32'(CLK_out & msk), 32'(ec[i]));
      chk($sformatf("%s.tick[%0d]", tag, i), 32'(TICK & msk), 32'(et[i]));
      chk($sformatf("%s.act[%0d]", tag, i), 32'(ACT & msk), 32'(ea[i]));
    end
  endtask

  initial begin
    RST = 1'b1; EN = '0; SYNC = 1'b0; DIV_ld = 1'b0; DIV_ch = '0; DIV_val = '0;
    #2;
    chk("rst.clk", 32'(CLK_out), 0);
    chk("rst.tick", 32'(TICK), 0);
    chk("rst.act", 32'(ACT), 0);
    step(); step();
    RST = 1'b0; EN = 3'b111;

    // reset release at DEF_DIV=2
    ec = '{3'b111, 3'b000, 3'b111, 3'b000};
    et = '{3'b111, 3'b000, 3'b111, 3'b000};
    ea = '{3'b111, 3'b111, 3'b111, 3'b111};
    play("def2");

    // ch1 N=4, load 5 at cnt=1
    do_reset();
    pulse_load(4'd1, 8'd4);
    EN = 3'b010;
    step();
    chk("n4.start", 32'(CLK_out), 32'(3'b010));
    step();
    DIV_ld = 1'b1; DIV_ch = 4'd1; DIV_val = 8'd5;
    ec = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000,
           3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
    et = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000,
           3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    ea = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
           3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    play("ld5");

    // ch0 N=6, EN dropped at cnt=1
    do_reset();
    pulse_load(4'd0, 8'd6);
    EN = 3'b001;
    step();
    chk("n6.tick0", 32'(TICK), 32'(3'b001));
    step();
    chk("n6.cnt1", 32'(CLK_out), 32'(3'b001));
    EN = 3'b000;
    ec = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    et = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    ea = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
    play("endis");

    // SYNC with ch0 N=3 and ch2 N=7 mid-period
    do_reset();
    pulse_load(4'd0, 8'd3);
    pulse_load(4'd2, 8'd7);
    EN = 3'b101;
    step(); step(); step();
    SYNC = 1'b1;
    ec = '{3'b101, 3'b101, 3'b100, 3'b101, 3'b001, 3'b000, 3'b001, 3'b101};
    et = '{3'b101, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b100};
    ea = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101};
    play("sync");

    // divisor 1 stops ch2 at its next boundary (ch2 now at cnt=0, N=7)
    msk = 3'b100;
    DIV_ld = 1'b1; DIV_ch = 4'd2; DIV_val = 8'd1;
    ec = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    et = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    ea = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
    play("stop1");
    msk = 3'b111;

    // out-of-range channel index changes nothing
    do_reset();
    pulse_load(4'd3, 8'd5);
    EN = 3'b111;
    ec = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b111};
    et = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b111};
    ea = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
    play("badch");

    // N=255: 128 high, 127 low
    do_reset();
    pulse_load(4'd0, 8'd255);
    EN = 3'b001;
    step();
    chk("n255.start", 32'(TICK & CLK_out), 32'(3'b001));
    hi = 0;
    repeat (254) begin
      step();
      hi += int'(CLK_out[0]);
    end
    chk("n255.hi_after_first", 32'(hi), 127);
    step();
    chk("n255.tick", 32'(TICK), 32'(3'b001));

    // async reset during a high phase
    #1;
    RST = 1'b1;
    #1;
    chk("arst.clk", 32'(CLK_out), 0);
    chk("arst.tick", 32'(TICK), 0);
    chk("arst.act", 32'(ACT), 0);
    EN = 3'b111;
    step();
    RST = 1'b0;
    ec = '{3'b111, 3'b000, 3'b111, 3'b000};
    et = '{3'b111, 3'b000, 3'b111, 3'b000};
    ea = '{3'b111, 3'b111, 3'b111, 3'b111};
    play("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
